// File: rtl/exc_ctrl_if.sv
// Pipeline-side bundle for the exception sequencer: EXE-stage event inputs, the
// CP0 MTC0/MFC0 ports and the kill/flush/redirect outputs.
interface exc_ctrl_if;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        alu_overflow;
    logic        e_eret;
    logic        intr;
    logic        c0_we;
    logic [4:0]  c0_waddr;
    logic [31:0] c0_wdata;
    logic [4:0]  c0_raddr;
    logic [31:0] c0_rdata;
    logic        e_kill;
    logic        flush;
    logic        pc_redir;
    logic [31:0] redir_pc;
    logic        exl;

    modport master (
        output e_valid, e_pc, alu_overflow, e_eret, intr,
        output c0_we, c0_waddr, c0_wdata, c0_raddr,
        input  c0_rdata, e_kill, flush, pc_redir, redir_pc, exl
    );

    modport slave (
        input  e_valid, e_pc, alu_overflow, e_eret, intr,
        input  c0_we, c0_waddr, c0_wdata, c0_raddr,
        output c0_rdata, e_kill, flush, pc_redir, redir_pc, exl
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer owning CP0 Status, Cause and EPC; kills, flushes and redirects.
// Define EXC_INTR_EN to enable the external interrupt path (otherwise only overflow and ERET).
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
    input  logic     clock,
    input  logic     resetn,
    exc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, TRAP, RET} state_t;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_OV  = 5'd12;
    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    state_t      state, state_nxt;
    logic        ie, exl_q, ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic        intr_eff;
    logic        in_run, ovf, ret, irq, c0_wr;

`ifdef EXC_INTR_EN
    assign intr_eff = bus.intr;
`else
    assign intr_eff = 1'b0;
`endif

    // Event priority: overflow > ERET > interrupt, only for a real instruction in RUN.
    assign in_run = (state == RUN) && bus.e_valid;
    assign ovf    = in_run && bus.alu_overflow;
    assign ret    = in_run && bus.e_eret && !ovf;
    assign irq    = in_run && intr_eff && ie && !exl_q && !ovf && !ret;
    assign c0_wr  = in_run && bus.c0_we && !(ovf || ret || irq);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = RUN;
        case (state)
            RUN: begin
                if (ovf || irq) state_nxt = TRAP;
                else if (ret)   state_nxt = RET;
                else            state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        bus.e_kill   = ovf || ret || irq;
        bus.flush    = 1'b0;
        bus.pc_redir = 1'b0;
        bus.redir_pc = EXC_VECTOR;
        case (state)
            TRAP: begin
                bus.flush    = 1'b1;
                bus.pc_redir = 1'b1;
            end
            RET: begin
                bus.flush    = 1'b1;
                bus.pc_redir = 1'b1;
                bus.redir_pc = epc;
            end
            default: ;
        endcase
    end

    // Hardware events take precedence over a same-cycle MTC0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ie       <= 1'b0;
            exl_q    <= 1'b0;
            ip       <= 1'b0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= intr_eff;
            if (ovf || irq) begin
                epc      <= bus.e_pc;
                exc_code <= ovf ? EXC_OV : EXC_INT;
                exl_q    <= 1'b1;
            end else if (ret) begin
                exl_q <= 1'b0;
            end else if (c0_wr) begin
                case (bus.c0_waddr)
                    ADDR_STATUS: {exl_q, ie} <= bus.c0_wdata[1:0];
                    ADDR_EPC:    epc         <= bus.c0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.c0_rdata = 32'd0;
        case (bus.c0_raddr)
            ADDR_STATUS: bus.c0_rdata = {30'd0, exl_q, ie};
            ADDR_CAUSE:  bus.c0_rdata = {21'd0, ip, 3'd0, exc_code, 2'd0};
            ADDR_EPC:    bus.c0_rdata = epc;
            default:     bus.c0_rdata = 32'd0;
        endcase
    end

    assign bus.exl = exl_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: vector table for event/CP0 behaviour, redirect scoreboard, and
// hand sequences for the flush window and reset during TRAP.
module tb_exc_ctrl;
`ifdef EXC_INTR_EN
    localparam int INTR = 1;
`else
    localparam int INTR = 0;
`endif

    logic clock;
    logic resetn;
    exc_ctrl_if bus();

    exc_ctrl #(.EXC_VECTOR(32'h0000_0004)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ovf, eret, intr, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        kill, redir;
        logic [31:0] tgt;
        logic [1:0]  status;
        logic [4:0]  code;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[18];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void chkb(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(int v, int pc, int ovf, int eret, int intr, int we, int wa,
                                int wd, int kill, int redir, int tgt, int st, int code, int epc);
        vec_t r;
        r.v = v[0]; r.pc = pc; r.ovf = ovf[0]; r.eret = eret[0]; r.intr = intr[0];
        r.we = we[0]; r.wa = wa[4:0]; r.wd = wd; r.kill = kill[0]; r.redir = redir[0];
        r.tgt = tgt; r.status = st[1:0]; r.code = code[4:0]; r.epc = epc;
        return r;
    endfunction

    // Every flush observed by the DUT must match the oldest expected redirect target.
    always @(negedge clock) begin
        if (resetn && bus.flush) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_flush: got redir_pc %h expected no flush", bus.redir_pc);
            end else begin
                logic [31:0] exp_t;
                exp_t = sb.pop_front();
                chk("redir_pc", bus.redir_pc, exp_t);
                chkb("pc_redir", bus.pc_redir, 1'b1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle(logic keep_intr);
        bus.e_valid = 1'b0; bus.e_pc = 32'd0; bus.alu_overflow = 1'b0; bus.e_eret = 1'b0;
        bus.intr = keep_intr; bus.c0_we = 1'b0; bus.c0_waddr = 5'd0; bus.c0_wdata = 32'd0;
    endtask

    task automatic drive_vec(vec_t t);
        bus.e_valid = t.v; bus.e_pc = t.pc; bus.alu_overflow = t.ovf; bus.e_eret = t.eret;
        bus.intr = t.intr; bus.c0_we = t.we; bus.c0_waddr = t.wa; bus.c0_wdata = t.wd;
    endtask

    task automatic readback(string tag, logic [1:0] st, logic [4:0] code, logic [31:0] epc, logic ip);
        bus.c0_raddr = 5'd12; #1 chk({tag, "_status"}, bus.c0_rdata, {30'd0, st});
        bus.c0_raddr = 5'd13; #1 chk({tag, "_cause"}, bus.c0_rdata, {21'd0, ip, 3'd0, code, 2'd0});
        bus.c0_raddr = 5'd14; #1 chk({tag, "_epc"}, bus.c0_rdata, epc);
        chkb({tag, "_exl"}, bus.exl, st[1]);
    endtask

    initial begin
        tbl[0]  = mk(1, 'h10,  0, 0, 0, 1, 14, 'h1234,     0, 0, 0,   0, 0,  'h1234);
        tbl[1]  = mk(1, 'h40,  1, 0, 0, 0, 0,  0,          1, 1, 4,   2, 12, 'h40);
        tbl[2]  = mk(1, 'h44,  0, 1, 0, 0, 0,  0,          1, 1, 'h40, 0, 12, 'h40);
        tbl[3]  = mk(0, 'h48,  1, 0, 0, 0, 0,  0,          0, 0, 0,   0, 12, 'h40);
        tbl[4]  = mk(1, 'h4C,  0, 0, 0, 1, 13, 'hFFFFFFFF, 0, 0, 0,   0, 12, 'h40);
        tbl[5]  = mk(1, 'h50,  0, 0, 0, 1, 12, 1,          0, 0, 0,   1, 12, 'h40);
        tbl[6]  = mk(1, 'h80,  1, 1, 0, 0, 0,  0,          1, 1, 4,   3, 12, 'h80);
        tbl[7]  = mk(1, 'h84,  0, 1, 0, 0, 0,  0,          1, 1, 'h80, 1, 12, 'h80);
        tbl[8]  = mk(1, 'h100, 0, 0, 1, 0, 0,  0, INTR, INTR, 4,
                     INTR ? 3 : 1, INTR ? 0 : 12, INTR ? 'h100 : 'h80);
        tbl[9]  = mk(1, 'h104, 0, 0, 1, 0, 0,  0, 0, 0, 0,
                     INTR ? 3 : 1, INTR ? 0 : 12, INTR ? 'h100 : 'h80);
        tbl[10] = mk(1, 'h108, 0, 1, 1, 0, 0,  0, 1, 1, INTR ? 'h100 : 'h80,
                     1, INTR ? 0 : 12, INTR ? 'h100 : 'h80);
        tbl[11] = mk(1, 'h200, 0, 0, 1, 0, 0,  0, INTR, INTR, 4,
                     INTR ? 3 : 1, INTR ? 0 : 12, INTR ? 'h200 : 'h80);
        tbl[12] = mk(1, 'h204, 0, 1, 0, 0, 0,  0, 1, 1, INTR ? 'h200 : 'h80,
                     1, INTR ? 0 : 12, INTR ? 'h200 : 'h80);
        tbl[13] = mk(1, 'h300, 1, 0, 1, 1, 14, 'hDEAD,     1, 1, 4,   3, 12, 'h300);
        tbl[14] = mk(1, 'h304, 0, 1, 1, 0, 0,  0,          1, 1, 'h300, 1, 12, 'h300);
        tbl[15] = mk(1, 'h400, 0, 0, 1, 0, 0,  0, INTR, INTR, 4,
                     INTR ? 3 : 1, INTR ? 0 : 12, INTR ? 'h400 : 'h300);
        tbl[16] = mk(1, 'h404, 0, 1, 0, 0, 0,  0, 1, 1, INTR ? 'h400 : 'h300,
                     1, INTR ? 0 : 12, INTR ? 'h400 : 'h300);
        tbl[17] = mk(1, 'h500, 0, 1, 0, 1, 14, 'h777, 1, 1, INTR ? 'h400 : 'h300,
                     1, INTR ? 0 : 12, INTR ? 'h400 : 'h300);

        resetn = 1'b0;
        drive_idle(1'b0);
        bus.c0_raddr = 5'd12;
        #1;
        chkb("rst_flush", bus.flush, 1'b0);
        chkb("rst_pc_redir", bus.pc_redir, 1'b0);
        chk("rst_redir_pc", bus.redir_pc, 32'h4);
        readback("rst", 2'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 18; i++) begin
            string tag;
            logic ip_e;
            tag = $sformatf("vec%0d", i);
            drive_vec(tbl[i]);
            if (tbl[i].redir) sb.push_back(tbl[i].tgt);
            #2 chkb({tag, "_e_kill"}, bus.e_kill, tbl[i].kill);
            @(posedge clock); #1;
            drive_idle(tbl[i].intr);
            @(posedge clock); #1;
            ip_e = (INTR != 0) && tbl[i].intr;
            readback(tag, tbl[i].status, tbl[i].code, tbl[i].epc, ip_e);
            @(posedge clock); #1;
        end

        // Flush window: a second overflow during TRAP must be ignored entirely.
        drive_idle(1'b0);
        bus.e_valid = 1'b1; bus.e_pc = 32'h600; bus.alu_overflow = 1'b1;
        sb.push_back(32'h4);
        #2 chkb("fw_kill_first", bus.e_kill, 1'b1);
        @(posedge clock); #1;
        bus.e_pc = 32'h700; bus.c0_we = 1'b1; bus.c0_waddr = 5'd14; bus.c0_wdata = 32'hBEEF;
        #1 chkb("fw_kill_in_trap", bus.e_kill, 1'b0);
        @(posedge clock); #1;
        drive_idle(1'b0);
        chkb("fw_no_second_flush", bus.flush, 1'b0);
        readback("fw", 2'd3, 5'd12, 32'h600, 1'b0);
        @(posedge clock); #1;
        bus.e_valid = 1'b1; bus.e_pc = 32'h604; bus.e_eret = 1'b1;
        sb.push_back(32'h600);
        @(posedge clock); #1;
        drive_idle(1'b0);
        @(posedge clock); #1;

        // Reset asserted while in TRAP drops flush/pc_redir without waiting for a clock.
        bus.e_valid = 1'b1; bus.e_pc = 32'h800; bus.alu_overflow = 1'b1;
        @(posedge clock); #1;
        drive_idle(1'b0);
        chkb("rt_flush_before", bus.flush, 1'b1);
        #1 resetn = 1'b0;
        #1;
        chkb("rt_flush", bus.flush, 1'b0);
        chkb("rt_pc_redir", bus.pc_redir, 1'b0);
        chk("rt_redir_pc", bus.redir_pc, 32'h4);
        readback("rt", 2'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        chkb("rt_run_flush", bus.flush, 1'b0);
        bus.e_valid = 1'b1; bus.e_pc = 32'h900; bus.alu_overflow = 1'b1;
        sb.push_back(32'h4);
        #2 chkb("rt_post_kill", bus.e_kill, 1'b1);
        @(posedge clock); #1;
        drive_idle(1'b0);
        @(posedge clock); #1;
        readback("rt_post", 2'd2, 5'd12, 32'h900, 1'b0);
        @(posedge clock); #1;

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt sequencer for the five-stage pipelined CPU. It sits beside the execute stage and watches the ALU overflow flag, the external interrupt line and ERET. It owns the CP0 Status, Cause and EPC registers. It kills the faulting instruction, flushes the pipeline and redirects fetch to the exception vector or back to EPC.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0004: handler entry address.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- e_valid  in  1  the instruction in EXE is real (not a bubble or flushed slot).
- e_pc  in  32  PC of the instruction in EXE.
- alu_overflow  in  1  overflow from EXE; already gated to add/sub.
- e_eret  in  1  the instruction in EXE is ERET.
- intr  in  1  external interrupt request, level-sensitive.
- c0_we  in  1  MTC0 in EXE.
- c0_waddr  in  5  CP0 register number for the write.
- c0_wdata  in  32  MTC0 data.
- c0_raddr  in  5  MFC0 read address.
- c0_rdata  out  32  combinational read data; unmapped addresses read 0.
- e_kill  out  1  combinational; suppresses the EXE instruction's MEM/WB side effects this cycle.
- flush  out  1  registered; clears IF/ID/EXE/MEM pipeline registers.
- pc_redir  out  1  registered; selects redir_pc as the next PC.
- redir_pc  out  32  redirect target.
- exl  out  1  Status.EXL.

## Operation
CP0 registers:
- Status (12): bit0 IE, bit1 EXL; all other bits read 0.
- Cause (13): bits[6:2] ExcCode (Int = 0, Ov = 12); bit10 IP = registered intr.
- EPC (14): 32-bit exception PC.

FSM states are RUN, TRAP and RET; reset state is RUN.

Event detection applies only in RUN with e_valid = 1. Priority is overflow > ERET > interrupt:
- ovf = alu_overflow.
- ret = e_eret & ~ovf.
- irq = intr & IE & ~EXL & ~ovf & ~ret.

On ovf or irq:
- e_kill = 1 in the same cycle.
- At the clock edge: EPC <= e_pc; ExcCode <= 12 (ovf) or 0 (irq); EXL <= 1; state <= TRAP.

On ret:
- e_kill = 1 in the same cycle.
- At the clock edge: EXL <= 0; state <= RET.

TRAP lasts 1 cycle: flush = 1, pc_redir = 1, redir_pc = EXC_VECTOR. Next state is RUN.

RET lasts 1 cycle: flush = 1, pc_redir = 1, redir_pc = EPC. Next state is RUN.

In TRAP and RET:
- All inputs are ignored, since the instructions are being flushed.
- e_kill = 0.
- No CP0 write is accepted.

MTC0:
- Writes Status[1:0] or EPC when in RUN, e_valid = 1 and no event fires that cycle.
- Writes to Cause and to other addresses are ignored.
- A hardware event in the same cycle wins and the MTC0 is dropped.

MFC0 reads the current register values, not the value being written in the same cycle.

An interrupt masked by EXL or IE = 0 remains pending as long as intr stays high. It is taken on the first eligible RUN cycle.

## Timing
- Cycle N: the event is seen and e_kill is high combinationally.
- Cycle N+1: TRAP or RET; flush and pc_redir are high.
- Cycle N+2: RUN; IF fetches the target.
- Redirect latency is 2 cycles from event to target fetch. Minimum spacing between two accepted events is 2 cycles.
- Reset values: state RUN; Status, Cause and EPC are 0; flush, pc_redir and exl are 0; redir_pc = EXC_VECTOR.
- Cause.IP is sampled every cycle.
- Reset asserted mid-TRAP or mid-RET returns to RUN immediately. flush and pc_redir drop asynchronously.

## Configuration
- EXC_INTR_EN defined: external interrupt path as above.
- EXC_INTR_EN undefined:
  - intr is ignored and irq is constant 0.
  - Cause.IP reads 0.
  - Status.IE stays writable but has no effect.
  - Only overflow and ERET are sequenced.

## Test plan
- Overflow: e_valid = 1, e_pc = 0x40, alu_overflow = 1 → e_kill = 1 the same cycle. Next cycle flush = pc_redir = 1 and redir_pc = 0x4. EPC = 0x40, ExcCode = 12, exl = 1.
- ERET after the overflow case: e_eret = 1 → next cycle redir_pc = 0x40 and exl = 0. The cycle after that returns to RUN.
- Interrupt (EXC_INTR_EN): MTC0 Status = 1, then intr = 1 with e_pc = 0x100 → TRAP, EPC = 0x100, ExcCode = 0. With intr held high, no second trap occurs while exl = 1.
- Simultaneous events: alu_overflow = 1, intr = 1 and c0_we to EPC = 0xDEAD in one cycle → ExcCode = 12, EPC = e_pc (the MTC0 is dropped). The interrupt is taken after ERET if intr is still high.
- Flush window: alu_overflow = 1 presented during TRAP → no effect; EPC unchanged, e_kill = 0.
- Reset during TRAP: resetn = 0 → flush = pc_redir = 0 immediately; Status, Cause and EPC are 0; state RUN.
